// File: rtl/tmds_pkg.sv
// Shared TMDS constants: control tokens and default lane geometry.
package tmds_pkg;

  localparam int unsigned TMDS_WIDTH = 10;
  localparam int unsigned TMDS_LANES = 3;

  // Control tokens indexed by C1C0.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // Token lookup by control pair {C1, C0}.
  function automatic logic [9:0] tmds_ctrl_token(input logic [1:0] c);
    logic [9:0] tok;
    unique case (c)
      2'b00:   tok = TMDS_CTRL_00;
      2'b01:   tok = TMDS_CTRL_01;
      2'b10:   tok = TMDS_CTRL_10;
      default: tok = TMDS_CTRL_11;
    endcase
    return tok;
  endfunction

endpackage

// File: rtl/lane_shifter.sv
// One lane: WIDTH-bit parallel-load shift register feeding a serial output.
module lane_shifter #(
  parameter int unsigned      WIDTH      = 10,
  parameter bit               LSB_FIRST  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_WORD = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             serial_o
);

  logic [WIDTH-1:0] sh_q, sh_d;

  // Load on word boundary, otherwise move the next bit toward the output end.
  always_comb begin
    sh_d = sh_q;
    if (load_i) begin
      sh_d = load_data_i;
    end else if (LSB_FIRST) begin
      sh_d = {1'b0, sh_q[WIDTH-1:1]};
    end else begin
      sh_d = {sh_q[WIDTH-2:0], 1'b0};
    end
  end

  // Shift register state; reset restarts on the idle token.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_q <= RESET_WORD;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign serial_o = LSB_FIRST ? sh_q[0] : sh_q[WIDTH-1];

endmodule

// File: rtl/tmds_lane_serializer.sv
// Multi-lane word-to-serial gearbox with one-deep skid buffer and idle-token
// insertion on underflow. All lanes share the bit counter and buffer.
module tmds_lane_serializer
  import tmds_pkg::*;
#(
  parameter int unsigned      WIDTH     = TMDS_WIDTH,
  parameter int unsigned      CHANNELS  = TMDS_LANES,
  parameter bit               LSB_FIRST = 1'b1,
  parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(TMDS_CTRL_00)
) (
  input  logic                      CLOCK_PX10,
  input  logic                      RESET,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS-1:0]       serial_out,
  output logic                      word_start,
  output logic                      underflow,
  output logic [15:0]               underflow_count
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [CntW-1:0]           cnt_q;
  logic                      buf_full_q;
  logic [CHANNELS*WIDTH-1:0] buf_data_q;
  logic                      underflow_q;
  logic [15:0]               underflow_count_q;

  logic load;
  logic accept;
  logic idle_load;

  // No bypass: a word lands in the buffer only while it is empty.
  assign in_ready   = !buf_full_q;
  assign accept     = in_valid & !buf_full_q;
  assign load       = (cnt_q == CntLast);
  assign idle_load  = load & !buf_full_q;
  assign word_start = (cnt_q == '0);

  // Bit counter, 0..WIDTH-1, wrapping at each load.
  always_ff @(posedge CLOCK_PX10) begin
    if (RESET) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Skid buffer: accepting and draining are mutually exclusive since accept needs it empty.
  always_ff @(posedge CLOCK_PX10) begin
    if (RESET) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
    end else if (accept) begin
      buf_full_q <= 1'b1;
      buf_data_q <= in_data;
    end else if (load) begin
      buf_full_q <= 1'b0;
    end
  end

  // Underflow pulse lines up with the word_start of the idle word; count saturates.
  always_ff @(posedge CLOCK_PX10) begin
    if (RESET) begin
      underflow_q       <= 1'b0;
      underflow_count_q <= '0;
    end else begin
      underflow_q <= idle_load;
      if (idle_load && (underflow_count_q != 16'hFFFF)) begin
        underflow_count_q <= underflow_count_q + 16'd1;
      end
    end
  end

  assign underflow       = underflow_q;
  assign underflow_count = underflow_count_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    logic [WIDTH-1:0] lane_load;

    assign lane_load = buf_full_q ? buf_data_q[k*WIDTH +: WIDTH] : IDLE_WORD;

    lane_shifter #(
      .WIDTH      (WIDTH),
      .LSB_FIRST  (LSB_FIRST),
      .RESET_WORD (IDLE_WORD)
    ) u_lane (
      .clk_i       (CLOCK_PX10),
      .rst_i       (RESET),
      .load_i      (load),
      .load_data_i (lane_load),
      .serial_o    (serial_out[k])
    );
  end

endmodule

// File: tb/tb_tmds_lane_serializer.sv
// Bench for tmds_lane_serializer: idle table, accept-timing and reset sequences,
// MSB-first lane check, and randomized traffic against a word-level model.
module tb_tmds_lane_serializer;

  localparam int W = 10;
  localparam int C = 3;
  localparam logic [W-1:0] IDLE = 10'b1101010100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default LSB-first.
  logic           rst_a, valid_a, ready_a, ws_a, uf_a;
  logic [C*W-1:0] data_a;
  logic [C-1:0]   serial_a;
  logic [15:0]    cnt_a;

  // Instance B: MSB-first.
  logic           rst_b, valid_b, ready_b, ws_b, uf_b;
  logic [C*W-1:0] data_b;
  logic [C-1:0]   serial_b;
  logic [15:0]    cnt_b;

  tmds_lane_serializer dut_a (
    .CLOCK_PX10      (clk),
    .RESET           (rst_a),
    .in_data         (data_a),
    .in_valid        (valid_a),
    .in_ready        (ready_a),
    .serial_out      (serial_a),
    .word_start      (ws_a),
    .underflow       (uf_a),
    .underflow_count (cnt_a)
  );

  tmds_lane_serializer #(
    .LSB_FIRST (1'b0)
  ) dut_b (
    .CLOCK_PX10      (clk),
    .RESET           (rst_b),
    .in_data         (data_b),
    .in_valid        (valid_b),
    .in_ready        (ready_b),
    .serial_out      (serial_b),
    .word_start      (ws_b),
    .underflow       (uf_b),
    .underflow_count (cnt_b)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Word-level reference: word currently on the wire, bit position within it,
  // and at most one pending word.
  logic [C*W-1:0] m_cur, m_buf;
  bit             m_full;
  int             m_pos;
  bit             m_uf;
  int             m_cnt;

  function automatic logic [C-1:0] word_bits(input logic [C*W-1:0] w, input int i);
    logic [C-1:0] e;
    for (int k = 0; k < C; k++) e[k] = w[k*W + i];
    return e;
  endfunction

  task automatic model_check(input string tag);
    chk({tag, "_serial"}, serial_a, word_bits(m_cur, m_pos));
    chk({tag, "_ws"}, ws_a, (m_pos == 0));
    chk({tag, "_ready"}, ready_a, !m_full);
    chk({tag, "_uf"}, uf_a, m_uf);
    chk({tag, "_ufcnt"}, cnt_a, m_cnt);
  endtask

  // One clock on instance A, advancing the model with the inputs seen at the edge.
  task automatic edge_a();
    bit acc;
    @(posedge clk);
    if (rst_a) begin
      m_pos = 0; m_cur = {C{IDLE}}; m_full = 0; m_uf = 0; m_cnt = 0;
    end else begin
      acc  = valid_a && !m_full;
      m_uf = 0;
      if (m_pos == W - 1) begin
        m_pos = 0;
        if (m_full) begin
          m_cur  = m_buf;
          m_full = 0;
        end else begin
          m_cur = {C{IDLE}};
          m_uf  = 1;
          if (m_cnt < 65535) m_cnt++;
        end
      end else begin
        m_pos++;
      end
      if (acc) begin
        m_buf  = data_a;
        m_full = 1;
      end
    end
    #1;
  endtask

  typedef struct {
    logic         valid;
    logic [C-1:0] exp_serial;
    logic         exp_ws;
    logic         exp_uf;
    logic [15:0]  exp_cnt;
    logic         exp_ready;
  } vec_t;

  vec_t tbl[30];

  initial begin
    logic [W-1:0]   idle_v;
    logic [C*W-1:0] x, y;
    int             low_ready, uf_pulses, pct, bound;
    bit             tog;

    idle_v = IDLE;
    for (int i = 0; i < 30; i++) begin
      tbl[i].valid      = 1'b0;
      tbl[i].exp_serial = {C{idle_v[i % W]}};
      tbl[i].exp_ws     = (i % W == 0);
      tbl[i].exp_uf     = (i % W == 0) && (i > 0);
      tbl[i].exp_cnt    = 16'(i / W);
      tbl[i].exp_ready  = 1'b1;
    end

    rst_a = 1; valid_a = 0; data_a = '0;
    rst_b = 1; valid_b = 0; data_b = '0;

    // MSB-first instance: reset state, then a word accepted at cnt == 8.
    @(posedge clk); #1;
    rst_b = 0;
    chk("b_reset_serial", serial_b, {C{idle_v[W-1]}});
    chk("b_reset_ws", ws_b, 1'b1);
    chk("b_reset_uf", uf_b, 1'b0);
    chk("b_reset_ready", ready_b, 1'b1);
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; end
    valid_b = 1;
    data_b  = {10'b0000000000, 10'b1100000000, 10'b1000000001};
    @(posedge clk); #1;
    valid_b = 0;
    chk("b_ready_low", ready_b, 1'b0);
    @(posedge clk); #1;
    chk("b_data_ws", ws_b, 1'b1);
    chk("b_data_uf", uf_b, 1'b0);
    for (int i = 0; i < W; i++) begin
      chk("b_lane_bits", serial_b, {1'b0, (i < 2) ? 1'b1 : 1'b0, (i == 0 || i == 9) ? 1'b1 : 1'b0});
      @(posedge clk); #1;
    end
    chk("b_ufcnt", cnt_b, 16'd1);

    // Instance A: reset, then idle-only table.
    edge_a();
    rst_a = 0;
    for (int i = 0; i < 30; i++) begin
      valid_a = tbl[i].valid;
      chk("idle_serial", serial_a, tbl[i].exp_serial);
      chk("idle_ws", ws_a, tbl[i].exp_ws);
      chk("idle_uf", uf_a, tbl[i].exp_uf);
      chk("idle_ufcnt", cnt_a, tbl[i].exp_cnt);
      chk("idle_ready", ready_a, tbl[i].exp_ready);
      edge_a();
    end
    chk("idle_ufcnt_30", cnt_a, 16'd3);

    // Accept at cnt == 8: data word starts two cycles later.
    for (int i = 0; i < 8; i++) begin model_check("pre8"); edge_a(); end
    chk("acc8_ready", ready_a, 1'b1);
    x = {$urandom, $urandom}; // upper bits truncated
    valid_a = 1; data_a = x;
    edge_a();
    valid_a = 0;
    chk("acc8_ready_low", ready_a, 1'b0);
    chk("acc8_not_yet", ws_a, 1'b0);
    edge_a();
    chk("acc8_ws", ws_a, 1'b1);
    chk("acc8_uf", uf_a, 1'b0);
    for (int i = 0; i < W; i++) begin
      chk("acc8_bits", serial_a, word_bits(x, i));
      model_check("acc8");
      if (i < W - 1) edge_a();
    end

    // Accept at cnt == 9: an idle word goes out first.
    y = ~x;
    valid_a = 1; data_a = y;
    edge_a();
    valid_a = 0;
    chk("acc9_idle_ws", ws_a, 1'b1);
    chk("acc9_idle_uf", uf_a, 1'b1);
    chk("acc9_idle_serial", serial_a, {C{idle_v[0]}});
    chk("acc9_ready_low", ready_a, 1'b0);
    for (int i = 0; i < W; i++) begin model_check("acc9i"); edge_a(); end
    chk("acc9_data_ws", ws_a, 1'b1);
    chk("acc9_data_uf", uf_a, 1'b0);
    for (int i = 0; i < W; i++) begin
      chk("acc9_bits", serial_a, word_bits(y, i));
      edge_a();
    end

    // Continuous valid, alternating all-ones / all-zeros words.
    valid_a = 1; tog = 0; low_ready = 0; uf_pulses = 0;
    for (int i = 0; i < 60; i++) begin
      data_a = tog ? '1 : '0;
      model_check("cont");
      if (i >= 20) begin
        if (!ready_a) low_ready++;
        if (uf_a) uf_pulses++;
      end
      if (ready_a) tog = ~tog;
      edge_a();
    end
    chk("cont_ready_low", low_ready, 36);
    chk("cont_no_underflow", uf_pulses, 0);

    // Reset in mid-word with the buffer full: buffered word is dropped.
    bound = 0;
    while (!(m_pos == 5 && m_full) && bound < 30) begin
      data_a = tog ? '1 : '0;
      if (ready_a) tog = ~tog;
      edge_a();
      bound++;
    end
    chk("rst_setup_found", (m_pos == 5 && m_full), 1'b1);
    chk("rst_setup_ready", ready_a, 1'b0);
    valid_a = 0; rst_a = 1;
    edge_a();
    rst_a = 0;
    chk("rst_ws", ws_a, 1'b1);
    chk("rst_serial", serial_a, {C{idle_v[0]}});
    chk("rst_ready", ready_a, 1'b1);
    chk("rst_ufcnt", cnt_a, 16'd0);
    for (int i = 0; i < 2 * W; i++) begin
      chk("rst_idle_bits", serial_a, {C{idle_v[i % W]}});
      model_check("rst");
      edge_a();
    end

    // Randomized traffic with varying load and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      case ((i / 250) % 3)
        0:       pct = 20;
        1:       pct = 60;
        default: pct = 95;
      endcase
      model_check("rnd");
      valid_a = ($urandom_range(0, 99) < pct);
      data_a  = {$urandom, $urandom};
      rst_a   = ($urandom_range(0, 199) == 0);
      edge_a();
    end
    rst_a = 0; valid_a = 0;
    model_check("end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
